alu_rr_arbiter: RTL and testbench

//   Shares one ALU instance between two requesters with round-robin arbitration.
//   It accepts one operation at a time over a valid/ready handshake and drives the ALU from registered operands.
//   It captures the ALU result and returns it on a single response channel tagged with the requester id.
//   It sits between issuing logic (e.g. two decode/execute clients) and the shared ALU.

---
 rtl/alu_rr_arbiter_if.sv | 50 +++++
 rtl/alu_rr_arbiter.sv | 94 +++++++++
 tb/tb_alu_rr_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_arbiter_if.sv
// Bundle of requester, ALU and response signals for alu_rr_arbiter.
// Signal suffixes are named from the arbiter's point of view.
interface alu_rr_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
);
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [WIDTH-1:0]  req0_data1_i;
    logic [WIDTH-1:0]  req0_data2_i;
    logic [CTRL_W-1:0] req0_ctrl_i;
    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [WIDTH-1:0]  req1_data1_i;
    logic [WIDTH-1:0]  req1_data2_i;
    logic [CTRL_W-1:0] req1_ctrl_i;
    logic [WIDTH-1:0]  alu_data1_o;
    logic [WIDTH-1:0]  alu_data2_o;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic [WIDTH-1:0]  alu_data_i;
    logic              alu_zero_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic              resp_id_o;
    logic [WIDTH-1:0]  resp_data_o;
    logic              resp_zero_o;
    logic              busy_o;
    logic [CNT_W-1:0]  done_cnt_o;

    modport slave (
        input  req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
        input  req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
        input  alu_data_i, alu_zero_i, resp_ready_i,
        output req0_ready_o, req1_ready_o,
        output alu_data1_o, alu_data2_o, alu_ctrl_o,
        output resp_valid_o, resp_id_o, resp_data_o, resp_zero_o,
        output busy_o, done_cnt_o
    );

    modport master (
        output req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
        output req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
        output alu_data_i, alu_zero_i, resp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  alu_data1_o, alu_data2_o, alu_ctrl_o,
        input  resp_valid_o, resp_id_o, resp_data_o, resp_zero_o,
        input  busy_o, done_cnt_o
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one op in flight,
// registered ALU operands, tagged response channel and completed-op counter.
module alu_rr_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    alu_rr_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q;
    logic              id_q;
    logic [WIDTH-1:0]  alu_data1_q, alu_data2_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic [WIDTH-1:0]  resp_data_q;
    logic              resp_zero_q;
    logic [CNT_W-1:0]  done_cnt_q;

    logic grant0, grant1, ready0, ready1, accept, resp_hs;

    // A lone requester always wins; on contention the one not served last wins.
    assign grant0  = bus.req0_valid_i & (~bus.req1_valid_i | last_grant_q);
    assign grant1  = bus.req1_valid_i & (~bus.req0_valid_i | ~last_grant_q);
    assign ready0  = (state_q == ST_IDLE) & grant0;
    assign ready1  = (state_q == ST_IDLE) & grant1;
    assign accept  = ready0 | ready1;
    assign resp_hs = (state_q == ST_RESP) & bus.resp_ready_i;

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)  state_d = ST_EXEC;
            ST_EXEC:              state_d = ST_RESP;
            ST_RESP: if (resp_hs) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers update with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q         <= ready1;
                last_grant_q <= ready1;
            end
            if (resp_hs) done_cnt_q <= done_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_data1_q <= '0;
            alu_data2_q <= '0;
            alu_ctrl_q  <= '0;
            resp_data_q <= '0;
            resp_zero_q <= 1'b0;
        end else begin
            if (accept) begin
                alu_data1_q <= ready1 ? bus.req1_data1_i : bus.req0_data1_i;
                alu_data2_q <= ready1 ? bus.req1_data2_i : bus.req0_data2_i;
                alu_ctrl_q  <= ready1 ? bus.req1_ctrl_i  : bus.req0_ctrl_i;
            end
            if (state_q == ST_EXEC) begin
                resp_data_q <= bus.alu_data_i;
                resp_zero_q <= bus.alu_zero_i;
            end
        end
    end

    assign bus.req0_ready_o = ready0;
    assign bus.req1_ready_o = ready1;
    assign bus.alu_data1_o  = alu_data1_q;
    assign bus.alu_data2_o  = alu_data2_q;
    assign bus.alu_ctrl_o   = alu_ctrl_q;
    assign bus.resp_valid_o = (state_q == ST_RESP);
    assign bus.resp_id_o    = id_q;
    assign bus.resp_data_o  = resp_data_q;
    assign bus.resp_zero_o  = resp_zero_q;
    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.done_cnt_o   = done_cnt_q;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed testbench for alu_rr_arbiter with a behavioural ALU on the ALU port.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_alu_rr_arbiter;
    localparam int WIDTH  = 32;
    localparam int CTRL_W = 3;
    localparam int CNT_W  = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   total = 0;
    int   bad   = 0;

    alu_rr_arbiter_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    alu_rr_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    // Reference ALU attached to the registered operand outputs.
    logic [WIDTH-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (bus.alu_ctrl_o)
            3'b000: alu_res = bus.alu_data1_o + bus.alu_data2_o;
            3'b001: alu_res = bus.alu_data1_o - bus.alu_data2_o;
            3'b010: alu_res = bus.alu_data1_o & bus.alu_data2_o;
            3'b011: alu_res = bus.alu_data1_o | bus.alu_data2_o;
            3'b100: alu_res = bus.alu_data1_o ^ bus.alu_data2_o;
            3'b101: alu_res = bus.alu_data1_o << bus.alu_data2_o[4:0];
            3'b110: alu_res = $signed(bus.alu_data1_o) >>> bus.alu_data2_o[4:0];
            default: alu_res = bus.alu_data1_o >> bus.alu_data2_o[4:0];
        endcase
    end
    assign bus.alu_data_i = alu_res;
    assign bus.alu_zero_i = (alu_res == '0);

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.req0_data1_i = '0; bus.req0_data2_i = '0; bus.req0_ctrl_i = '0;
        bus.req1_data1_i = '0; bus.req1_data2_i = '0; bus.req1_ctrl_i = '0;
        bus.resp_ready_i = 1'b1;
        #3 rst_i = 1'b1;
        #1;
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy_o); end
        total++; if (bus.resp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid_o); end
        total++; if ({bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o} !== '0) begin bad++; $display("FAIL rst_alu_regs got=%h exp=0", {bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o}); end
        total++; if ({bus.resp_id_o, bus.resp_data_o, bus.resp_zero_o} !== '0) begin bad++; $display("FAIL rst_resp_regs got=%h exp=0", {bus.resp_id_o, bus.resp_data_o, bus.resp_zero_o}); end
        total++; if (bus.done_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_done_cnt got=%0d exp=0", bus.done_cnt_o); end
        step();
        rst_i = 1'b0;
        step();
        bus.req0_valid_i = 1'b1;
        #1;
        total++; if (bus.req0_ready_o !== 1'b1) begin bad++; $display("FAIL rst_first_ready0 got=%b exp=1", bus.req0_ready_o); end
        total++; if (bus.req1_ready_o !== 1'b0) begin bad++; $display("FAIL rst_first_ready1 got=%b exp=0", bus.req1_ready_o); end
        bus.req0_valid_i = 1'b0;
        #1;
        total++; if (bus.req0_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready0_novalid got=%b exp=0", bus.req0_ready_o); end
    endtask

    task automatic test_single_op();
        step();
        bus.req0_valid_i = 1'b1;
        bus.req0_data1_i = 32'h5; bus.req0_data2_i = 32'h7; bus.req0_ctrl_i = 3'b000;
        #1;
        total++; if (bus.req0_ready_o !== 1'b1) begin bad++; $display("FAIL t2_ready0 got=%b exp=1", bus.req0_ready_o); end
        step();
        bus.req0_valid_i = 1'b0;
        #1;
        total++; if ({bus.busy_o, bus.resp_valid_o, bus.req0_ready_o} !== 3'b100) begin bad++; $display("FAIL t2_exec_state busy/valid/ready got=%b exp=100", {bus.busy_o, bus.resp_valid_o, bus.req0_ready_o}); end
        total++; if ({bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o} !== {32'h5, 32'h7, 3'b000}) begin bad++; $display("FAIL t2_alu_operands got=%h exp=%h", {bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o}, {32'h5, 32'h7, 3'b000}); end
        step();
        #1;
        total++; if (bus.resp_valid_o !== 1'b1) begin bad++; $display("FAIL t2_resp_valid got=%b exp=1", bus.resp_valid_o); end
        total++; if ({bus.resp_id_o, bus.resp_data_o, bus.resp_zero_o} !== {1'b0, 32'h0000000C, 1'b0}) begin bad++; $display("FAIL t2_resp got id/data/zero=%b/%h/%b exp=0/0000000c/0", bus.resp_id_o, bus.resp_data_o, bus.resp_zero_o); end
        step();
        #1;
        total++; if ({bus.busy_o, bus.resp_valid_o} !== 2'b00) begin bad++; $display("FAIL t2_back_idle got=%b exp=00", {bus.busy_o, bus.resp_valid_o}); end
        total++; if (bus.done_cnt_o !== 16'd1) begin bad++; $display("FAIL t2_done_cnt got=%0d exp=1", bus.done_cnt_o); end
    endtask

    task automatic test_zero_flag();
        step();
        bus.req1_valid_i = 1'b1;
        bus.req1_data1_i = 32'h1234; bus.req1_data2_i = 32'h1234; bus.req1_ctrl_i = 3'b001;
        #1;
        total++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b01) begin bad++; $display("FAIL t5_ready got=%b exp=01", {bus.req0_ready_o, bus.req1_ready_o}); end
        step();
        bus.req1_valid_i = 1'b0;
        step();
        #1;
        total++; if ({bus.resp_valid_o, bus.resp_id_o, bus.resp_data_o, bus.resp_zero_o} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin bad++; $display("FAIL t5_resp got v/id/data/zero=%b/%b/%h/%b exp=1/1/00000000/1", bus.resp_valid_o, bus.resp_id_o, bus.resp_data_o, bus.resp_zero_o); end
        step();
        #1;
        total++; if (bus.done_cnt_o !== 16'd2) begin bad++; $display("FAIL t5_done_cnt got=%0d exp=2", bus.done_cnt_o); end
    endtask

    task automatic test_contention();
        logic [WIDTH-1:0] exp_data;
        step();
        bus.req0_valid_i = 1'b1;
        bus.req0_data1_i = 32'h10; bus.req0_data2_i = 32'h3; bus.req0_ctrl_i = 3'b001;
        bus.req1_valid_i = 1'b1;
        bus.req1_data1_i = 32'h80000000; bus.req1_data2_i = 32'h4; bus.req1_ctrl_i = 3'b110;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if ({bus.req0_ready_o, bus.req1_ready_o} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL t3_grant%0d got=%b exp=%b", k, {bus.req0_ready_o, bus.req1_ready_o}, (k % 2 == 0) ? 2'b10 : 2'b01); end
            step();
            step();
            #1;
            exp_data = (k % 2 == 0) ? 32'h0000000D : 32'hF8000000;
            total++; if ({bus.resp_valid_o, bus.resp_id_o, bus.resp_data_o} !== {1'b1, k[0], exp_data}) begin bad++; $display("FAIL t3_resp%0d got v/id/data=%b/%b/%h exp=1/%b/%h", k, bus.resp_valid_o, bus.resp_id_o, bus.resp_data_o, k[0], exp_data); end
            step();
        end
        idle_inputs();
        #1;
        total++; if (bus.done_cnt_o !== 16'd6) begin bad++; $display("FAIL t3_done_cnt got=%0d exp=6", bus.done_cnt_o); end
    endtask

    task automatic test_backpressure();
        step();
        bus.resp_ready_i = 1'b0;
        bus.req0_valid_i = 1'b1;
        bus.req0_data1_i = 32'hFF00; bus.req0_data2_i = 32'h0F0F; bus.req0_ctrl_i = 3'b100;
        step();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b1;
        bus.req1_data1_i = 32'h3; bus.req1_data2_i = 32'h2; bus.req1_ctrl_i = 3'b101;
        step();
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if ({bus.resp_valid_o, bus.resp_id_o, bus.resp_data_o} !== {1'b1, 1'b0, 32'h0000F00F}) begin bad++; $display("FAIL t4_hold%0d got v/id/data=%b/%b/%h exp=1/0/0000f00f", c, bus.resp_valid_o, bus.resp_id_o, bus.resp_data_o); end
            total++; if ({bus.req0_ready_o, bus.req1_ready_o, bus.alu_ctrl_o} !== {2'b00, 3'b100}) begin bad++; $display("FAIL t4_no_accept%0d got rdy/ctrl=%b/%b exp=00/100", c, {bus.req0_ready_o, bus.req1_ready_o}, bus.alu_ctrl_o); end
            step();
        end
        bus.resp_ready_i = 1'b1;
        step();
        #1;
        total++; if ({bus.busy_o, bus.done_cnt_o} !== {1'b0, 16'd7}) begin bad++; $display("FAIL t4_release got busy/cnt=%b/%0d exp=0/7", bus.busy_o, bus.done_cnt_o); end
        total++; if (bus.req1_ready_o !== 1'b1) begin bad++; $display("FAIL t4_next_ready1 got=%b exp=1", bus.req1_ready_o); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_exec();
        step();
        bus.req0_valid_i = 1'b1;
        bus.req0_data1_i = 32'h1; bus.req0_data2_i = 32'h1; bus.req0_ctrl_i = 3'b000;
        step();
        idle_inputs();
        #1;
        total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL t6_in_exec got=%b exp=1", bus.busy_o); end
        rst_i = 1'b1;
        #1;
        total++; if ({bus.busy_o, bus.resp_valid_o, bus.done_cnt_o} !== {2'b00, 16'd0}) begin bad++; $display("FAIL t6_async_clear got busy/valid/cnt=%b/%b/%0d exp=0/0/0", bus.busy_o, bus.resp_valid_o, bus.done_cnt_o); end
        #1 rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            #1;
            total++; if ({bus.resp_valid_o, bus.busy_o} !== 2'b00) begin bad++; $display("FAIL t6_no_resp%0d got valid/busy=%b/%b exp=0/0", c, bus.resp_valid_o, bus.busy_o); end
        end
        bus.req0_valid_i = 1'b1;
        bus.req1_valid_i = 1'b1;
        #1;
        total++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b10) begin bad++; $display("FAIL t6_req0_wins got=%b exp=10", {bus.req0_ready_o, bus.req1_ready_o}); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_zero_flag();
        test_contention();
        test_backpressure();
        test_reset_mid_exec();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
